// File: rtl/ab_ptc_input_enforcer.sv
// Enforces the ab policy on raw plant A/B before they reach the controller.
// Latency: one cycle, every output is registered from the sampled inputs.
// Backpressure: none; raw plant events are sampled every cycle and never stalled.
module ab_ptc_input_enforcer #(
    parameter int MAX_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A_ptc_in,
    input  logic       B_ptc_in,
    input  logic       clear_count,
    output logic       A_ptc_out,
    output logic       B_ptc_out,
    output logic [2:0] recovery_ref,
    output logic [1:0] state_out,
    output logic [7:0] edit_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1
    } state_t;

    localparam logic [2:0] REF_NONE     = 3'd0;
    localparam logic [2:0] REF_DROP_B   = 3'd1;
    localparam logic [2:0] REF_ORPHAN_B = 3'd2;
    localparam logic [2:0] REF_DROP_A   = 3'd3;
    localparam logic [2:0] REF_TIMEOUT  = 3'd4;

    // Last legal tick value before the missing B is synthesised.
    localparam logic [7:0] V_LAST = 8'(MAX_TICKS - 1);

    state_t     state_q, state_d;
    logic [7:0] v_q, v_d;
    logic       a_d, b_d;
    logic [2:0] ref_d;
    logic [7:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            v_q          <= 8'd0;
            A_ptc_out    <= 1'b0;
            B_ptc_out    <= 1'b0;
            recovery_ref <= REF_NONE;
            edit_count   <= 8'd0;
        end else begin
            state_q      <= state_d;
            v_q          <= v_d;
            A_ptc_out    <= a_d;
            B_ptc_out    <= b_d;
            recovery_ref <= ref_d;
            edit_count   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        a_d     = 1'b0;
        b_d     = 1'b0;
        ref_d   = REF_NONE;
        unique case (state_q)
            IDLE: begin
                if (A_ptc_in) begin
                    a_d     = 1'b1;
                    ref_d   = B_ptc_in ? REF_DROP_B : REF_NONE;
                    state_d = WAIT;
                    v_d     = 8'd0;
                end else if (B_ptc_in) begin
                    ref_d = REF_ORPHAN_B;
                end
            end
            WAIT: begin
                // A real B wins over the timeout, which wins over A suppression.
                if (B_ptc_in) begin
                    b_d     = 1'b1;
                    ref_d   = A_ptc_in ? REF_DROP_A : REF_NONE;
                    state_d = IDLE;
                    v_d     = 8'd0;
                end else if (v_q == V_LAST) begin
                    b_d     = 1'b1;
                    ref_d   = REF_TIMEOUT;
                    state_d = IDLE;
                    v_d     = 8'd0;
                end else begin
                    ref_d = A_ptc_in ? REF_DROP_A : REF_NONE;
                    v_d   = v_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                v_d     = 8'd0;
            end
        endcase
    end

    always_comb begin
        cnt_d = edit_count;
        if (clear_count) begin
            cnt_d = 8'd0;
        end else if (ref_d != REF_NONE && edit_count != 8'hFF) begin
            cnt_d = edit_count + 8'd1;
        end
    end

    assign state_out = state_q;

endmodule

// File: doc/ab_ptc_input_enforcer.md
# ab_ptc_input_enforcer

Clocked runtime enforcer for the plant-to-controller (ptc) direction of the `ab` interface. It complements the ctp output enforcers. It samples raw plant signals `A_ptc_in`/`B_ptc_in` and applies the `ab` policy: A must be followed by B within `MAX_TICKS` cycles, with no B without a pending A and no repeated A while one is pending. It presents edited, registered signals to the controller, together with a recovery reference and a saturating edit count.

## Interface
- `MAX_TICKS`, 5: response window in cycles after an accepted A; legal range 1..255.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `A_ptc_in`  in  1  raw plant event A, sampled every cycle.
- `B_ptc_in`  in  1  raw plant event B, sampled every cycle.
- `clear_count`  in  1  synchronous clear of `edit_count`.
- `A_ptc_out`  out  1  enforced A, registered.
- `B_ptc_out`  out  1  enforced B, registered.
- `recovery_ref`  out  3  edit applied in the last sampled cycle, registered.
- `state_out`  out  2  policy state: 0 = IDLE, 1 = WAIT; 2 and 3 are unused.
- `edit_count`  out  8  number of cycles with `recovery_ref` ≠ 0, saturating at 255.

## Operation
- Internal state:
  - FSM with states IDLE and WAIT.
  - 8-bit tick counter `v`, meaningful only in WAIT.
- Per cycle, evaluate the sampled `(A, B)` against the current state. Only the first matching rule applies.
- **IDLE** rules:
  - `A=1, B=1`: pass A, drop B, ref=1, go to WAIT, v←0.
  - `A=1, B=0`: pass A, ref=0, go to WAIT, v←0.
  - `A=0, B=1`: drop B, ref=2, stay in IDLE.
  - `A=0, B=0`: pass, ref=0, stay in IDLE.
- **WAIT** rules:
  - `B=1`: pass B. If A=1, drop A and set ref=3; otherwise ref=0. Go to IDLE.
  - `B=0` and `v == MAX_TICKS-1`: timeout. Force B_out=1, drop A, ref=4, go to IDLE.
  - `B=0, A=1`, no timeout: drop A, ref=3, v←v+1, stay in WAIT.
  - `B=0, A=0`, no timeout: pass, ref=0, v←v+1, stay in WAIT.
- **Priority in WAIT:** a real B beats the timeout. The timeout beats suppression of a repeated A.
- **Edit counter:**
  - `edit_count` increments when the newly registered ref ≠ 0.
  - It holds at 255.
  - `clear_count=1` sets it to 0 for that cycle; the clear wins over a same-cycle increment.
- **Invariants on outputs:**
  - `A_ptc_out` and `B_ptc_out` are never both 1.
  - `recovery_ref` values 5–7 are never produced.

## Timing
- **Reset:** while `rst_n=0`, all of the following hold immediately, regardless of clock:
  - `A_ptc_out=0`, `B_ptc_out=0`, `recovery_ref=0`.
  - `state_out=0` (IDLE), `v=0`, `edit_count=0`.
- **Reset mid-WAIT:** a pending A is abandoned and no forced B is emitted. After release, the first sampled cycle is evaluated from IDLE.
- **Latency:** inputs sampled at edge k appear on the outputs after edge k. `state_out` reflects the state after edge k.
- **Timeout placement:** with A accepted at sampled cycle t and no B afterwards, forced B is the sample at cycle t+MAX_TICKS.
  - `MAX_TICKS=1`: forced B at t+1 when B is absent.
- **Back-to-back transactions:** an A arriving in the same cycle as a B that closes WAIT is dropped (ref=3), not accepted. A new A is accepted only from IDLE.
- **No combinational paths:** no output depends combinationally on any input.

## Test plan
- **Reset values and normal handshake:** assert reset → all outputs 0. Then release, A at cycle 0, B at cycle 2 → outputs A=1 then B=1 one cycle later, every ref=0, state 0→1→1→0, edit_count=0.
- **Orphan B and simultaneous A/B from IDLE:**
  - B alone in IDLE → B_out=0, ref=2.
  - Then A=B=1 → A_out=1, B_out=0, ref=1, state=1.
  - edit_count=2.
- **Timeout at the boundary (MAX_TICKS=5):**
  - A at cycle 0, no B → B_out=1 for the cycle-5 sample, ref=4, state=0.
  - Same setup with B at cycle 5 → real B passes, ref=0.
- **Repeated A in WAIT:**
  - A at cycle 0, A at 1 and 2 → A_out=0 for both, ref=3.
  - A with B at cycle 3 → B_out=1, A_out=0, ref=3.
  - edit_count=3.
- **Reset mid-WAIT:** A at cycle 0, `rst_n` pulsed low asynchronously at cycle 2 → outputs clear immediately, no forced B at cycle 5, state=0.
- **Saturation and clear:** 300 orphan Bs → edit_count holds at 255. Then `clear_count=1` with a concurrent edit → edit_count=0 next cycle.
